mem_stage_ls: RTL

MEM_STAGE_LS -- requirements
Module: mem_stage_ls

---
 rtl/mem_stage_ls_if.sv | 38 +++
 rtl/mem_stage_ls.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mem_stage_ls_if.sv
// Handshake and data bundle around the memory stage: upstream entry,
// load response, downstream handshake and hazard-check view.
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where the producer's valid and the consumer's ready/allow are both 1.
// A producer holds its payload stable while valid=1 and ready=0.
interface mem_stage_ls_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) ();
   localparam int ES_WD = 1 + 1 + 3 + RA_W + 2 * XLEN;
   localparam int WS_WD = 1 + RA_W + 2 * XLEN;

   logic               es_to_ms_valid;
   logic [ES_WD-1:0]   es_to_ms_bus;
   logic               ms_allow_in;
   logic               ms_flush;
   logic               data_sram_data_ok;
   logic [XLEN-1:0]    data_sram_rdata;
   logic               ws_allow_in;
   logic               ms_to_ws_valid;
   logic [WS_WD-1:0]   ms_to_ws_bus;
   logic [RA_W+2:0]    ms_to_che_bus;

   // Stage side
   modport slave (
      input  es_to_ms_valid, es_to_ms_bus, ms_flush,
             data_sram_data_ok, data_sram_rdata, ws_allow_in,
      output ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_che_bus
   );

   // Surrounding pipeline / memory side
   modport master (
      output es_to_ms_valid, es_to_ms_bus, ms_flush,
             data_sram_data_ok, data_sram_rdata, ws_allow_in,
      input  ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_che_bus
   );
endinterface

// File: rtl/mem_stage_ls.sv
// Memory stage with a single entry slot: waits for load responses, extends
// load data by ld_op and byte offset, and forwards the result to writeback.
// Responses belonging to flushed loads are counted and discarded.
module mem_stage_ls #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_stage_ls_if.slave         ms_if,
   output logic [1:0]            dbg_state_o
);
   localparam int ES_WD = 1 + 1 + 3 + RA_W + 2 * XLEN;
   localparam int WS_WD = 1 + RA_W + 2 * XLEN;
   localparam int OFF_W = $clog2(XLEN / 8);

   typedef enum logic [1:0] {EMPTY = 2'd0, WAIT = 2'd1, READY = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [1:0]       drop_cnt_q, drop_cnt_d;
   logic [ES_WD-1:0] entry_q, entry_d;
   logic [XLEN-1:0]  result_q, result_d;

   // Fields of the held entry
   logic             e_is_load, e_rf_we;
   logic [2:0]       e_ld_op;
   logic [RA_W-1:0]  e_dest;
   logic [XLEN-1:0]  e_pc, e_alu;
   logic             in_is_load;
   logic [XLEN-1:0]  in_alu;

   assign e_alu      = entry_q[XLEN-1:0];
   assign e_pc       = entry_q[2*XLEN-1:XLEN];
   assign e_dest     = entry_q[2*XLEN+RA_W-1:2*XLEN];
   assign e_ld_op    = entry_q[2*XLEN+RA_W+2:2*XLEN+RA_W];
   assign e_rf_we    = entry_q[ES_WD-2];
   assign e_is_load  = entry_q[ES_WD-1];
   assign in_is_load = ms_if.es_to_ms_bus[ES_WD-1];
   assign in_alu     = ms_if.es_to_ms_bus[XLEN-1:0];

   logic             allow_in, capture;
   logic [OFF_W-1:0] ld_off;
   logic [XLEN-1:0]  ld_shift, ld_ext;

   // While stale responses are outstanding no new entry may enter, so the
   // slot is always EMPTY whenever drop_cnt is non-zero.
   assign allow_in = (drop_cnt_q == 2'd0) &&
                     ((state_q == EMPTY) || ((state_q == READY) && ms_if.ws_allow_in));
   assign capture  = ms_if.es_to_ms_valid && allow_in;

   assign ld_off   = e_alu[OFF_W-1:0];
   assign ld_shift = ms_if.data_sram_rdata >> {ld_off, 3'b000};

   // Load data extension. For XLEN=32 the D and WU encodings reduce to the
   // full shifted word, which is exactly the W result.
   always_comb begin
      ld_ext = '0;
      case (e_ld_op)
         3'b000:  ld_ext = XLEN'($signed(ld_shift[31:0]));
         3'b001:  ld_ext = XLEN'($signed(ld_shift[7:0]));
         3'b010:  ld_ext = XLEN'($signed(ld_shift[15:0]));
         3'b011:  ld_ext = XLEN'(ld_shift[7:0]);
         3'b100:  ld_ext = XLEN'(ld_shift[15:0]);
         3'b101:  ld_ext = ld_shift;
         3'b110:  ld_ext = XLEN'(ld_shift[31:0]);
         default: ld_ext = '0;
      endcase
   end

   // Next-state: flush beats completion and capture; capture beats drain.
   always_comb begin
      state_d    = state_q;
      drop_cnt_d = drop_cnt_q;
      entry_d    = entry_q;
      result_d   = result_q;
      if (ms_if.ms_flush) begin
         state_d = EMPTY;
         if ((state_q == WAIT) && !ms_if.data_sram_data_ok)
            drop_cnt_d = drop_cnt_q + 2'd1;
      end else begin
         if (ms_if.data_sram_data_ok && (drop_cnt_q != 2'd0))
            drop_cnt_d = drop_cnt_q - 2'd1;
         case (state_q)
            EMPTY: ;
            WAIT: begin
               if (ms_if.data_sram_data_ok && (drop_cnt_q == 2'd0)) begin
                  state_d  = READY;
                  result_d = ld_ext;
               end
            end
            READY: begin
               if (ms_if.ws_allow_in) state_d = EMPTY;
            end
            default: state_d = EMPTY;
         endcase
         if (capture) begin
            entry_d  = ms_if.es_to_ms_bus;
            state_d  = in_is_load ? WAIT : READY;
            result_d = in_is_load ? '0 : in_alu;
         end
      end
   end

   // State and data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         drop_cnt_q <= 2'd0;
         entry_q    <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         drop_cnt_q <= drop_cnt_d;
         entry_q    <= entry_d;
         result_q   <= result_d;
      end
   end

   assign ms_if.ms_allow_in    = allow_in;
   assign ms_if.ms_to_ws_valid = (state_q == READY);
   assign ms_if.ms_to_ws_bus   = WS_WD'({e_rf_we, e_dest, e_pc, result_q});
   assign ms_if.ms_to_che_bus  = {(state_q != EMPTY), (state_q == WAIT), e_rf_we, e_dest};
   assign dbg_state_o          = state_q;

   // e_is_load only matters through the captured state; keep it visible.
   logic unused_ok;
   assign unused_ok = e_is_load;
endmodule
